// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   Clk    in   1  clock, rising edge
//   Reset  in   1  asynchronous active-low reset
//   A      in  32  operand rs
//   B      in  32  operand rt
//   Op     in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   Start  in   1  qualifies Op for one cycle
//   Busy   out  1  high while a mult/div is in flight
//   HI     out 32  HI register
//   LO     out 32  LO register
//
// Configuration: define MDU_DIV_EN to build the divider (Op 3/4). Without it,
// Op 3/4 are no-ops and no divider logic is present.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Results are formed from captured operands only and committed on the
    // final Busy edge.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] prod;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        prod   = sgn_q ? prod_s : prod_u;
    end

`ifdef MDU_DIV_EN
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    // Signed division via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000
    // because its magnitude is representable as unsigned.
    always_comb begin
        a_neg = sgn_q & a_q[31];
        b_neg = sgn_q & b_q[31];
        a_mag = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag = b_neg ? (~b_q + 32'd1) : b_q;
        b_div = (b_q == '0) ? 32'd1 : b_mag;  // result discarded when B is 0
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        3'd1, 3'd2: begin
                            state_d = MUL;
                            cnt_d   = 4'(MULT_CYCLES);
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (Op == 3'd1);
                        end
`ifdef MDU_DIV_EN
                        3'd3, 3'd4: begin
                            state_d = DIV;
                            cnt_d   = 4'(DIV_CYCLES);
                            a_d     = A;
                            b_d     = B;
                            sgn_d   = (Op == 3'd3);
                        end
`endif
                        3'd5: hi_d = A;
                        3'd6: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu with default MULT_CYCLES=5, DIV_CYCLES=10.
// Expected mult/div results are queued at issue time and checked when Busy
// falls; immediate ops (mthi/mtlo/no-op/reset) are checked directly.
module tb_mdu;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic [2:0]  Op    = '0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .A    (A),
        .B    (B),
        .Op   (Op),
        .Start(Start),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] busy_cnt = '0;
    logic [31:0] hold_hi, hold_lo;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: HI/LO must hold during Busy; on Busy falling, compare result
    // and Busy length against the scoreboard head.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            busy_cnt = '0;
        end else if (Busy) begin
            if (busy_cnt == 0) begin
                hold_hi = HI;
                hold_lo = LO;
            end else begin
                chk("hold_hi", HI, hold_hi);
                chk("hold_lo", LO, hold_lo);
            end
            busy_cnt = busy_cnt + 1;
        end else if (busy_cnt != 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got HI=%h LO=%h expected no result", HI, LO);
            end else begin
                e = sb.pop_front();
                chk("res_hi", HI, e.hi);
                chk("res_lo", LO, e.lo);
                chk("busy_cycles", busy_cnt, e.cyc);
            end
            busy_cnt = '0;
        end
    end

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] cyc);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Drives one Start pulse, then scrambles the operand inputs so any use of
    // live A/B/Op after acceptance corrupts the result.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = 3'd2;
        A     = 32'hDEADBEEF;
        B     = 32'h5A5A5A5A;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got Busy=1 expected Busy=0 within 40 cycles");
        end
        @(negedge Clk);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge Clk);
        #1 Reset = 1'b1;

        // Start accepted on first edge after release
        Op = 3'd5; A = 32'h11111111; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        chk("mthi_first_edge", HI, 32'h11111111);
        chk("mthi_busy", {31'b0, Busy}, 32'd0);

        issue(3'd6, 32'h22222222, 32'h0);
        chk("mtlo", LO, 32'h22222222);
        chk("mtlo_hi_kept", HI, 32'h11111111);

        issue(3'd0, 32'h33333333, 32'h0);
        issue(3'd7, 32'h44444444, 32'h0);
        chk("nop_busy", {31'b0, Busy}, 32'd0);
        chk("nop_hi", HI, 32'h11111111);
        chk("nop_lo", LO, 32'h22222222);

        // mult -2 * 3
        push(32'hFFFFFFFF, 32'hFFFFFFFA, 32'd5);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_busy", {31'b0, Busy}, 32'd1);
        wait_idle();

        // multu max * max
        push(32'hFFFFFFFE, 32'h00000001, 32'd5);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();

        // mtlo during Busy is ignored; result is the product 6*7
        push(32'h00000000, 32'h0000002A, 32'd5);
        issue(3'd1, 32'd6, 32'd7);
        @(posedge Clk);
        issue(3'd6, 32'h00001234, 32'h0);
        chk("busy_during_mtlo", {31'b0, Busy}, 32'd1);
        wait_idle();

`ifdef MDU_DIV_EN
        push(32'hFFFFFFFF, 32'hFFFFFFFD, 32'd10);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 32'd10);
        issue(3'd4, 32'd7, 32'd0);
        wait_idle();

        push(32'h00000000, 32'h80000000, 32'd10);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        push(32'h0000000F, 32'h0FFFFFFF, 32'd10);
        issue(3'd4, 32'hFFFFFFFF, 32'h00000010);
        wait_idle();
`else
        issue(3'd3, 32'd9, 32'd3);
        chk("nodiv_busy", {31'b0, Busy}, 32'd0);
        issue(3'd4, 32'd9, 32'd3);
        repeat (3) @(negedge Clk);
        chk("nodiv_busy2", {31'b0, Busy}, 32'd0);
        chk("nodiv_hi", HI, 32'h00000000);
        chk("nodiv_lo", LO, 32'h0000002A);
`endif

        // Reset mid-operation at Busy cycle 4
        issue(3'd5, 32'h00000055, 32'h0);
        chk("pre_rst_hi", HI, 32'h00000055);
`ifdef MDU_DIV_EN
        issue(3'd3, 32'd100, 32'd7);
`else
        issue(3'd1, 32'd100, 32'd7);
`endif
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, Busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        chk("postrst_hi", HI, 32'd0);
        chk("postrst_busy", {31'b0, Busy}, 32'd0);
        issue(3'd5, 32'h0000ABCD, 32'h0);
        chk("postrst_mthi", HI, 32'h0000ABCD);
        chk("postrst_lo", LO, 32'd0);

        repeat (3) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
